// File: rtl/la_pkg.sv
// Shared constants and FSM encodings for the logic-analyzer trigger and
// the sample counter wrapper.
package la_pkg;

    localparam int STATE_BITS    = 3;
    localparam int LA_WIDTH      = 8;
    localparam int LA_DELAY_BITS = 16;

    typedef enum logic [STATE_BITS-1:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } la_state_e;

endpackage

// File: rtl/la_trigger_match.sv
// Probe synchroniser, previous-sample register and masked level/edge match
// against the latched trigger configuration.
module la_trigger_match
    import la_pkg::*;
#(
    parameter int WIDTH = LA_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] probe_i,
    input  logic [WIDTH-1:0] mask_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic [WIDTH-1:0] edge_i,
    input  logic             prime_i,
    output logic             match_o
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] bit_ok;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            s_q     <= '0;
            p_q     <= '0;
        end else begin
            sync1_q <= probe_i;
            s_q     <= sync1_q;
            p_q     <= s_q;
        end
    end

    // An edge channel needs the current level at value and the previous one away from it.
    assign bit_ok  = ~mask_i | (~(s_q ^ value_i) & (~edge_i | (p_q ^ value_i)));
    assign match_o = (&bit_ok) & ~prime_i;

endmodule

// File: rtl/la_trigger.sv
// Trigger/arming FSM: latches config on arm, waits for a probe match plus an
// optional delay, then holds start until the sample counter reports full.
module la_trigger
    import la_pkg::*;
#(
    parameter int WIDTH      = LA_WIDTH,
    parameter int DELAY_BITS = LA_DELAY_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [WIDTH-1:0]      probe,
    input  logic [WIDTH-1:0]      trig_mask,
    input  logic [WIDTH-1:0]      trig_value,
    input  logic [WIDTH-1:0]      trig_edge,
    input  logic [DELAY_BITS-1:0] trig_delay,
    input  logic                  max_samples_reached,
    output logic                  start,
    output logic                  counter_clear,
    output logic                  armed,
    output logic                  triggered,
    output logic                  done,
    output logic [STATE_BITS-1:0] state
);

    la_state_e             state_q, state_d;
    logic [WIDTH-1:0]      mask_q, mask_d;
    logic [WIDTH-1:0]      value_q, value_d;
    logic [WIDTH-1:0]      edge_q, edge_d;
    logic [DELAY_BITS-1:0] delay_q, delay_d;
    logic [DELAY_BITS-1:0] cnt_q, cnt_d;
    logic                  prime_q, prime_d;
    logic                  clear_d;
    logic                  start_q, clear_q, armed_q, triggered_q, done_q;
    logic                  match;

    la_trigger_match #(.WIDTH(WIDTH)) u_match (
        .clock   (clock),
        .reset   (reset),
        .probe_i (probe),
        .mask_i  (mask_q),
        .value_i (value_q),
        .edge_i  (edge_q),
        .prime_i (prime_q),
        .match_o (match)
    );

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        value_d = value_q;
        edge_d  = edge_q;
        delay_d = delay_q;
        cnt_d   = cnt_q;
        prime_d = 1'b0;
        clear_d = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_d = ST_ARMED;
                        mask_d  = trig_mask;
                        value_d = trig_value;
                        edge_d  = trig_edge;
                        delay_d = trig_delay;
                        prime_d = 1'b1;
                        clear_d = 1'b1;
                    end
                end
                ST_ARMED: begin
                    // match is already suppressed during the prime cycle
                    if (match) begin
                        if (delay_q == '0) begin
                            state_d = ST_CAPTURE;
                        end else begin
                            state_d = ST_DELAY;
                            cnt_d   = delay_q - DELAY_BITS'(1);
                        end
                    end
                end
                ST_DELAY: begin
                    if (cnt_q == '0) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        cnt_d = cnt_q - DELAY_BITS'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (max_samples_reached) begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            value_q     <= '0;
            edge_q      <= '0;
            delay_q     <= '0;
            cnt_q       <= '0;
            prime_q     <= 1'b0;
            start_q     <= 1'b0;
            clear_q     <= 1'b0;
            armed_q     <= 1'b0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            value_q     <= value_d;
            edge_q      <= edge_d;
            delay_q     <= delay_d;
            cnt_q       <= cnt_d;
            prime_q     <= prime_d;
            start_q     <= (state_d == ST_CAPTURE);
            clear_q     <= clear_d;
            armed_q     <= (state_d == ST_ARMED);
            triggered_q <= (state_d == ST_DELAY) || (state_d == ST_CAPTURE);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign start         = start_q;
    assign counter_clear = clear_q;
    assign armed         = armed_q;
    assign triggered     = triggered_q;
    assign done          = done_q;
    assign state         = state_q;

endmodule

// File: tb/tb_la_trigger.sv
// Bench for la_trigger: per-cycle reference scoreboard plus directed latency checks.
module tb_la_trigger;

    localparam int W  = 8;
    localparam int DB = 16;
    localparam int S_IDLE = 0, S_ARMED = 1, S_DELAY = 2, S_CAPTURE = 3, S_DONE = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          arm = 1'b0, abort = 1'b0, msr = 1'b0;
    logic [W-1:0]  probe = '0, trig_mask = '0, trig_value = '0, trig_edge = '0;
    logic [DB-1:0] trig_delay = '0;
    logic          start, counter_clear, armed, triggered, done;
    logic [2:0]    state;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [W-1:0]  m_sync1 = '0, m_s = '0, m_p = '0, m_mask = '0, m_val = '0, m_edg = '0;
    logic [DB-1:0] m_dly = '0, m_cnt = '0;
    int            m_st = S_IDLE;
    bit            m_prime = 1'b0;
    logic [7:0]    exp_q[$];

    la_trigger #(.WIDTH(W), .DELAY_BITS(DB)) dut (
        .clock               (clock),
        .reset               (reset),
        .arm                 (arm),
        .abort               (abort),
        .probe               (probe),
        .trig_mask           (trig_mask),
        .trig_value          (trig_value),
        .trig_edge           (trig_edge),
        .trig_delay          (trig_delay),
        .max_samples_reached (msr),
        .start               (start),
        .counter_clear       (counter_clear),
        .armed               (armed),
        .triggered           (triggered),
        .done                (done),
        .state               (state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {start, counter_clear, armed, triggered, done, state};
    endfunction

    // Predict the post-edge outputs from the current inputs, clock once, then compare.
    task automatic cyc();
        bit            mt;
        int            n_st;
        logic [DB-1:0] n_cnt;
        bit            n_prime, clr;
        logic [W-1:0]  n_mask, n_val, n_edg;
        logic [DB-1:0] n_dly;
        logic [7:0]    e;
        mt = 1'b1;
        for (int i = 0; i < W; i++)
            if (m_mask[i] && (m_s[i] != m_val[i] || (m_edg[i] && m_p[i] == m_val[i]))) mt = 1'b0;
        if (m_prime) mt = 1'b0;
        n_st = m_st; n_cnt = m_cnt; n_prime = 1'b0; clr = 1'b0;
        n_mask = m_mask; n_val = m_val; n_edg = m_edg; n_dly = m_dly;
        if (abort) n_st = S_IDLE;
        else case (m_st)
            S_IDLE, S_DONE:
                if (arm) begin
                    n_st = S_ARMED; clr = 1'b1; n_prime = 1'b1;
                    n_mask = trig_mask; n_val = trig_value; n_edg = trig_edge; n_dly = trig_delay;
                end
            S_ARMED:
                if (mt) begin
                    if (m_dly == 0) n_st = S_CAPTURE;
                    else begin n_st = S_DELAY; n_cnt = m_dly - 1'b1; end
                end
            S_DELAY:
                if (m_cnt == 0) n_st = S_CAPTURE;
                else n_cnt = m_cnt - 1'b1;
            S_CAPTURE:
                if (msr) n_st = S_DONE;
            default: n_st = S_IDLE;
        endcase
        if (reset) begin
            n_st = S_IDLE; n_cnt = '0; n_prime = 1'b0; clr = 1'b0;
            n_mask = '0; n_val = '0; n_edg = '0; n_dly = '0;
            e = 8'h00;
        end else begin
            e = {n_st == S_CAPTURE, clr, n_st == S_ARMED,
                 n_st == S_DELAY || n_st == S_CAPTURE, n_st == S_DONE, 3'(n_st)};
        end
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        m_p     = reset ? '0 : m_s;
        m_s     = reset ? '0 : m_sync1;
        m_sync1 = reset ? '0 : probe;
        m_st = n_st; m_cnt = n_cnt; m_prime = n_prime;
        m_mask = n_mask; m_val = n_val; m_edg = n_edg; m_dly = n_dly;
        chk("scoreboard", 32'(outs()), 32'(exp_q.pop_front()));
    endtask

    task automatic do_arm(input logic [W-1:0] msk, input logic [W-1:0] val,
                          input logic [W-1:0] edg, input logic [DB-1:0] dly);
        trig_mask = msk; trig_value = val; trig_edge = edg; trig_delay = dly;
        arm = 1'b1;
        cyc();
        arm = 1'b0;
        chk("arm_clear", 32'(counter_clear), 32'd1);
        chk("arm_armed", 32'(armed), 32'd1);
        trig_mask = ~msk; trig_value = ~val; trig_edge = ~edg; trig_delay = dly ^ 16'h0003;
        cyc();
        chk("clear_1cyc", 32'(counter_clear), 32'd0);
    endtask

    // Cycles until start is observed high, bounded.
    task automatic wait_start(input string tag, input int limit, output int n);
        n = 0;
        while (start !== 1'b1 && n < limit) begin
            cyc();
            n++;
        end
        if (start !== 1'b1) chk({tag, "_timeout"}, 32'(start), 32'd1);
    endtask

    initial begin
        int n;
        repeat (3) cyc();
        chk("reset_outs", 32'(outs()), 32'h0);
        reset = 1'b0;
        cyc();

        // level trigger
        probe = 8'h00;
        do_arm(8'h01, 8'h01, 8'h00, 16'd0);
        repeat (9) cyc();
        chk("lvl_idle_start", 32'(start), 32'd0);
        probe = 8'h01;
        wait_start("lvl", 10, n);
        chk("lvl_latency", 32'(n), 32'd3);
        repeat (5) cyc();
        chk("lvl_hold", 32'(start), 32'd1);

        // completion
        msr = 1'b1;
        cyc();
        msr = 1'b0;
        chk("done_start", 32'(start), 32'd0);
        chk("done_set", 32'(done), 32'd1);
        probe = 8'h80;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (done === 1'b1) n++;
        end
        chk("done_held", 32'(n), 32'd20);

        // rising edge, bit already high at arm; re-arm from DONE
        do_arm(8'h80, 8'h80, 8'h80, 16'd0);
        repeat (8) cyc();
        chk("edge_no_trig", 32'(start), 32'd0);
        probe = 8'h00;
        repeat (3) cyc();
        chk("edge_fall_no_trig", 32'(start), 32'd0);
        probe = 8'h80;
        wait_start("edge", 10, n);
        chk("edge_latency", 32'(n), 32'd3);

        // abort in CAPTURE
        abort = 1'b1; cyc(); abort = 1'b0;
        chk("abort_cap_state", 32'(state), 32'd0);
        chk("abort_cap_start", 32'(start), 32'd0);

        // delay 5, mask 0: first eligible cycle is the one after the prime cycle
        trig_mask = '0;
        trig_delay = 16'd5;
        arm = 1'b1; cyc(); arm = 1'b0;
        wait_start("dly5", 20, n);
        chk("dly5_latency", 32'(n - 1), 32'd6);

        // abort in DELAY
        abort = 1'b1; cyc(); abort = 1'b0;
        do_arm(8'h00, 8'h00, 8'h00, 16'd5);
        cyc();
        chk("in_delay", 32'(triggered), 32'd1);
        abort = 1'b1; cyc(); abort = 1'b0;
        chk("abort_dly_state", 32'(state), 32'd0);
        chk("abort_dly_start", 32'(start), 32'd0);

        // abort in ARMED
        probe = 8'h00;
        do_arm(8'h01, 8'h01, 8'h00, 16'd0);
        abort = 1'b1; cyc(); abort = 1'b0;
        chk("abort_arm_state", 32'(state), 32'd0);

        // abort beats arm from IDLE
        abort = 1'b1; arm = 1'b1; cyc(); abort = 1'b0; arm = 1'b0;
        chk("abort_arm_same", 32'(state), 32'd0);
        chk("abort_arm_clear", 32'(counter_clear), 32'd0);

        // maximum delay
        trig_mask = '0; trig_delay = 16'hFFFF;
        arm = 1'b1; cyc(); arm = 1'b0;
        wait_start("dlymax", 70000, n);
        chk("dlymax_latency", 32'(n - 1), 32'd65536);

        // reset mid-CAPTURE, then stray max_samples_reached in IDLE
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("rst_cap_outs", 32'(outs()), 32'h0);
        msr = 1'b1; cyc(); msr = 1'b0;
        cyc();
        chk("stray_msr", 32'(outs()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
